key_conditioner: RTL and testbench



---
 rtl/key_conditioner.sv | 124 ++++++++++++
 tb/tb_key_conditioner.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/key_conditioner.sv
// Pushbutton front end: per-key synchronizer, debouncer and optional auto-repeat,
// turning bouncing active-low KEY pins into clean levels and press/release pulses.
module key_conditioner #(
  parameter int          N_KEYS          = 4,
  parameter int          DEBOUNCE_CYCLES = 500000,
  parameter int          REPEAT_DELAY    = 25000000,
  parameter int          REPEAT_PERIOD   = 5000000,
  parameter logic [N_KEYS-1:0] REPEAT_MASK = 4'b0011
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [N_KEYS-1:0] key_n,
  output logic [N_KEYS-1:0] level,
  output logic [N_KEYS-1:0] press,
  output logic [N_KEYS-1:0] release_pulse
);

  localparam int DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int REP_W   = $clog2(REP_MAX + 1);

  localparam logic [DB_W-1:0]  DB_LAST     = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [REP_W-1:0] DELAY_LAST  = REP_W'(REPEAT_DELAY - 1);
  localparam logic [REP_W-1:0] PERIOD_LAST = REP_W'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {
    IDLE,
    DELAY,
    PERIOD
  } rep_state_t;

  for (genvar i = 0; i < N_KEYS; i++) begin : g_key
    logic             sync1_n;
    logic             sync_n;
    logic             stab;
    logic [DB_W-1:0]  db_cnt;
    logic             accept;
    logic             press_evt;
    logic             release_evt;
    rep_state_t       state;
    logic [REP_W-1:0] rep_cnt;
    logic             level_q;
    logic             press_q;
    logic             release_q;

    // stab holds the accepted raw (active-low) state; accept marks the edge it flips.
    assign accept      = (sync_n != stab) && (db_cnt == DB_LAST);
    assign press_evt   = accept && !sync_n;
    assign release_evt = accept && sync_n;

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        sync1_n <= 1'b1;
        sync_n  <= 1'b1;
        stab    <= 1'b1;
        db_cnt  <= '0;
      end else begin
        sync1_n <= key_n[i];
        sync_n  <= sync1_n;
        if (sync_n == stab) begin
          db_cnt <= '0;
        end else if (accept) begin
          stab   <= sync_n;
          db_cnt <= '0;
        end else begin
          db_cnt <= db_cnt + DB_W'(1);
        end
      end
    end

    // Outputs are registered from the accept event so they change on the same edge as stab.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        state     <= IDLE;
        rep_cnt   <= '0;
        level_q   <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
      end else begin
        if (accept) level_q <= !sync_n;
        release_q <= release_evt;
        press_q   <= press_evt;
        case (state)
          IDLE: begin
            rep_cnt <= '0;
            if (REPEAT_MASK[i] && press_evt) state <= DELAY;
          end
          DELAY: begin
            if (release_evt) begin
              state   <= IDLE;
              rep_cnt <= '0;
            end else if (rep_cnt == DELAY_LAST) begin
              press_q <= 1'b1;
              rep_cnt <= '0;
              state   <= PERIOD;
            end else begin
              rep_cnt <= rep_cnt + REP_W'(1);
            end
          end
          PERIOD: begin
            if (release_evt) begin
              state   <= IDLE;
              rep_cnt <= '0;
            end else if (rep_cnt == PERIOD_LAST) begin
              press_q <= 1'b1;
              rep_cnt <= '0;
            end else begin
              rep_cnt <= rep_cnt + REP_W'(1);
            end
          end
          default: begin
            state   <= IDLE;
            rep_cnt <= '0;
          end
        endcase
      end
    end

    assign level[i]         = level_q;
    assign press[i]         = press_q;
    assign release_pulse[i] = release_q;
  end

endmodule

// File: tb/tb_key_conditioner.sv
// Directed bench for key_conditioner with short debounce/repeat timing;
// per-cycle vector tables plus hand-written reset sequences.
module tb_key_conditioner;

  logic       clk;
  logic       reset_n;
  logic [3:0] key_n;
  logic [3:0] level;
  logic [3:0] press;
  logic [3:0] release_pulse;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int         scen;
    int         edge_no;
    logic [3:0] key_n;
    logic [3:0] lv;
    logic [3:0] pr;
    logic [3:0] rl;
  } vec_t;

  vec_t vecs[$];

  key_conditioner #(
    .N_KEYS(4),
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY(10),
    .REPEAT_PERIOD(3),
    .REPEAT_MASK(4'b0011)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .key_n(key_n),
    .level(level),
    .press(press),
    .release_pulse(release_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [3:0] lv,
                             input logic [3:0] pr, input logic [3:0] rl);
    total++;
    if ({level, press, release_pulse} !== {lv, pr, rl}) begin
      bad++;
      $display("[TB] FAIL %s: got level=%b press=%b release=%b, want level=%b press=%b release=%b",
               name, level, press, release_pulse, lv, pr, rl);
    end
  endtask

  // Drive one cycle of key_n, step past the next edge, then compare.
  task automatic applyStimulus(input vec_t v);
    key_n = v.key_n;
    @(posedge clk);
    #1;
    checkOutput($sformatf("s%0d_e%0d", v.scen, v.edge_no), v.lv, v.pr, v.rl);
  endtask

  task automatic push(input int scen, input int e, input logic [3:0] kn,
                      input logic [3:0] lv, input logic [3:0] pr, input logic [3:0] rl);
    vec_t v;
    v.scen = scen; v.edge_no = e; v.key_n = kn; v.lv = lv; v.pr = pr; v.rl = rl;
    vecs.push_back(v);
  endtask

  initial begin
    logic [3:0] kn, lv, pr, rl;

    // Scenario 2: key 0 held 8 cycles, press at 6, release accepted at 14.
    for (int e = 1; e <= 20; e++) begin
      kn = (e <= 8) ? 4'b1110 : 4'b1111;
      lv = (e >= 6 && e <= 13) ? 4'b0001 : 4'b0000;
      pr = (e == 6) ? 4'b0001 : 4'b0000;
      rl = (e == 14) ? 4'b0001 : 4'b0000;
      push(2, e, kn, lv, pr, rl);
    end
    // Scenario 3: key 2 bounces LLLH for 40 cycles, then held low until cycle 52.
    for (int e = 1; e <= 62; e++) begin
      if (e <= 40)      kn = (((e - 1) % 4) == 3) ? 4'b1111 : 4'b1011;
      else if (e <= 52) kn = 4'b1011;
      else              kn = 4'b1111;
      lv = (e >= 46 && e <= 57) ? 4'b0100 : 4'b0000;
      pr = (e == 46) ? 4'b0100 : 4'b0000;
      rl = (e == 58) ? 4'b0100 : 4'b0000;
      push(3, e, kn, lv, pr, rl);
    end
    // Scenario 4: keys 1 (repeat) and 3 (no repeat) held 40 cycles.
    for (int e = 1; e <= 50; e++) begin
      kn = (e <= 40) ? 4'b0101 : 4'b1111;
      lv = (e >= 6 && e <= 45) ? 4'b1010 : 4'b0000;
      pr = 4'b0000;
      if (e == 6) pr = 4'b1010;
      else if (e >= 16 && e <= 43 && ((e - 16) % 3) == 0) pr = 4'b0010;
      rl = (e == 46) ? 4'b1010 : 4'b0000;
      push(4, e, kn, lv, pr, rl);
    end
    // Scenario 5: key 1 released after edge 17; no press from the release cycle on.
    for (int e = 1; e <= 28; e++) begin
      kn = (e <= 17) ? 4'b1101 : 4'b1111;
      lv = (e >= 6 && e <= 22) ? 4'b0010 : 4'b0000;
      pr = (e == 6 || e == 16 || e == 19 || e == 22) ? 4'b0010 : 4'b0000;
      rl = (e == 23) ? 4'b0010 : 4'b0000;
      push(5, e, kn, lv, pr, rl);
    end

    // Test 1: reset with every key held down.
    reset_n = 1'b0;
    key_n   = 4'b0000;
    #1;
    checkOutput("rst_hold_t0", 4'b0000, 4'b0000, 4'b0000);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      checkOutput($sformatf("rst_hold_c%0d", k), 4'b0000, 4'b0000, 4'b0000);
    end
    reset_n = 1'b1;
    for (int e = 1; e <= 10; e++) begin
      @(posedge clk);
      #1;
      checkOutput($sformatf("s1_e%0d", e), (e >= 6) ? 4'b1111 : 4'b0000,
                  (e == 6) ? 4'b1111 : 4'b0000, 4'b0000);
    end

    // Test 6: mid-hold reset clears outputs at once, then re-accepts without a release.
    reset_n = 1'b0;
    #1;
    checkOutput("s6_async_clear", 4'b0000, 4'b0000, 4'b0000);
    @(posedge clk);
    @(posedge clk);
    #1;
    checkOutput("s6_in_reset", 4'b0000, 4'b0000, 4'b0000);
    reset_n = 1'b1;
    for (int e = 1; e <= 10; e++) begin
      @(posedge clk);
      #1;
      checkOutput($sformatf("s6_e%0d", e), (e >= 6) ? 4'b1111 : 4'b0000,
                  (e == 6) ? 4'b1111 : 4'b0000, 4'b0000);
    end

    // Release everything; keys 0/1 would repeat on the release edge but must not.
    key_n = 4'b1111;
    for (int e = 1; e <= 8; e++) begin
      @(posedge clk);
      #1;
      checkOutput($sformatf("s6r_e%0d", e), (e < 6) ? 4'b1111 : 4'b0000,
                  4'b0000, (e == 6) ? 4'b1111 : 4'b0000);
    end

    foreach (vecs[idx]) applyStimulus(vecs[idx]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
